// File: rtl/pcs_64b66b_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, error-block codes and scrambler taps.
// The encoder and decoder both import this package.
package pcs_64b66b_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam logic [7:0] BT_ERROR = 8'h1E;
   localparam logic [6:0] CH_ERROR = 7'h1E;

   localparam int SCR_TAP_A = 38;
   localparam int SCR_TAP_B = 57;

   typedef logic [65:0] blk66_t;

   // Control block of eight /E/ characters, used in place of an illegal word
   localparam logic [63:0] ERROR_PAYLOAD = {{8{CH_ERROR}}, BT_ERROR};

   function automatic logic is_legal_type(input logic [1:0] ttype);
      return (ttype == SYNC_DATA) || (ttype == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/encoder_64b66b_if.sv
// Valid/ready stream with an optional side-band type field.
// The same definition serves both the typed 64-bit input and the 66-bit block output.
interface encoder_64b66b_if #(
   parameter int DATA_W = 64,
   parameter int TYPE_W = 2
) ();

   logic [DATA_W-1:0] tdata;
   logic [TYPE_W-1:0] ttype;
   logic              tvalid;
   logic              tready;

   modport master (
      output tdata,
      output ttype,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  ttype,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/encoder_64b66b_scrambler.sv
// Self-synchronous x^58+x^39+1 scrambler, all 64 payload bits in one combinational step.
// Bit 0 goes first; state bit 0 holds the most recently scrambled bit.
module pcs_scrambler58
   import pcs_64b66b_pkg::*;
(
   input  logic [63:0] data_in,
   input  logic [57:0] state_in,
   output logic [63:0] data_out,
   output logic [57:0] state_out
);

   logic [57:0] state_walk;

   always_comb begin
      state_walk = state_in;
      data_out   = '0;
      for (int i = 0; i < 64; i++) begin
         data_out[i] = data_in[i] ^ state_walk[SCR_TAP_A] ^ state_walk[SCR_TAP_B];
         state_walk  = {state_walk[56:0], data_out[i]};
      end
      state_out = state_walk;
   end

endmodule

// File: rtl/encoder_64b66b.sv
// 64b/66b transmit encoder: sync header, error substitution for illegal word types,
// optional payload scrambling and a single skid-free output register stage.
module encoder_64b66b
   import pcs_64b66b_pkg::*;
#(
   parameter int          SCR_EN    = 1,
   parameter logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF,
   parameter int          ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   encoder_64b66b_if.slave      s_axis,
   encoder_64b66b_if.master     m_axis,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic                 accept;
   logic                 type_legal;
   logic [1:0]           hdr_next;
   logic [63:0]          raw_payload;
   logic [63:0]          scr_payload;
   logic [63:0]          payload_next;
   logic [57:0]          scr_state_reg;
   logic [57:0]          scr_state_next;
   blk66_t               blk_reg;
   logic                 valid_reg;
   logic [ERR_CNT_W-1:0] err_cnt_reg;

   // Ready looks through the output register so a full pipeline never bubbles
   assign s_axis.tready = !valid_reg || m_axis.tready;
   assign accept        = s_axis.tvalid && s_axis.tready;

   always_comb begin
      type_legal  = is_legal_type(s_axis.ttype);
      hdr_next    = type_legal ? s_axis.ttype : SYNC_CTRL;
      raw_payload = type_legal ? s_axis.tdata : ERROR_PAYLOAD;
   end

   pcs_scrambler58 u_scrambler (
      .data_in   (raw_payload),
      .state_in  (scr_state_reg),
      .data_out  (scr_payload),
      .state_out (scr_state_next)
   );

   assign payload_next = (SCR_EN != 0) ? scr_payload : raw_payload;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blk_reg       <= '0;
         valid_reg     <= 1'b0;
         scr_state_reg <= SCR_SEED;
         err_cnt_reg   <= '0;
      end else begin
         if (accept) begin
            blk_reg   <= {payload_next, hdr_next};
            valid_reg <= 1'b1;
            // Scrambler only advances for words that actually go out
            if (SCR_EN != 0) begin
               scr_state_reg <= scr_state_next;
            end
            if (!type_legal && !(&err_cnt_reg)) begin
               err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
         end else if (m_axis.tready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign m_axis.tdata  = blk_reg;
   assign m_axis.tvalid = valid_reg;
   assign m_axis.ttype  = '0;
   assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_encoder_64b66b.sv
// Bench for encoder_64b66b: three instances (unscrambled, zero seed, default seed) share one
// stimulus stream; outputs are descrambled by a stream-level model and matched to a scoreboard.
module tb_encoder_64b66b;

   localparam logic [57:0] SEED_DEF    = 58'h3FF_FFFF_FFFF_FFFF;
   localparam logic [57:0] SEED_ZERO   = 58'h0;
   localparam logic [63:0] ERR_PAYLOAD = {{8{7'h1E}}, 8'h1E};

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  ttype = 2'b00;
   logic [63:0] tdata = 64'h0;
   logic        tvalid = 1'b0;
   logic        m_tready = 1'b0;
   logic [15:0] err0, err1, err2;

   int vectors = 0;
   int miscompares = 0;

   logic [65:0] exp_q[$];
   logic [15:0] err_model = '0;
   logic [57:0] hist1, hist2;
   logic        chk_zero = 1'b0;

   always #5 clk = ~clk;

   encoder_64b66b_if #(.DATA_W(64), .TYPE_W(2)) in0 (), in1 (), in2 ();
   encoder_64b66b_if #(.DATA_W(66), .TYPE_W(1)) out0 (), out1 (), out2 ();

   assign in0.ttype = ttype;  assign in0.tdata = tdata;  assign in0.tvalid = tvalid;
   assign in1.ttype = ttype;  assign in1.tdata = tdata;  assign in1.tvalid = tvalid;
   assign in2.ttype = ttype;  assign in2.tdata = tdata;  assign in2.tvalid = tvalid;
   assign out0.tready = m_tready;
   assign out1.tready = m_tready;
   assign out2.tready = m_tready;

   encoder_64b66b #(.SCR_EN(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .s_axis(in0), .m_axis(out0), .err_cnt(err0));
   encoder_64b66b #(.SCR_EN(1), .SCR_SEED(SEED_ZERO)) dut1 (
      .clk(clk), .reset_n(reset_n), .s_axis(in1), .m_axis(out1), .err_cnt(err1));
   encoder_64b66b #(.SCR_EN(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .s_axis(in2), .m_axis(out2), .err_cnt(err2));

   task automatic check(input string tag, input logic [65:0] observed, input logic [65:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Received history as a bit stream, oldest bit at index 0 (last 58 line bits)
   function automatic logic [57:0] seed_hist(input logic [57:0] seed);
      logic [57:0] h;
      for (int j = 0; j < 58; j++) h[j] = seed[57 - j];
      return h;
   endfunction

   // Line bit n descrambles as s[n] ^ s[n-39] ^ s[n-58]; returns {new history, payload}
   function automatic logic [121:0] descramble(input logic [63:0] s, input logic [57:0] hist);
      logic [121:0] r;
      logic [63:0]  d;
      r = {s, hist};
      for (int i = 0; i < 64; i++) d[i] = s[i] ^ r[i + 19] ^ r[i];
      return {r[121:64], d};
   endfunction

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_tvalid0", out0.tvalid, 1'b0);
      check("rst_tvalid2", out2.tvalid, 1'b0);
      check("rst_tdata2", out2.tdata, 66'h0);
      check("rst_err0", err0, 16'h0);
      check("rst_err2", err2, 16'h0);
      exp_q.delete();
      err_model = '0;
      hist1 = seed_hist(SEED_ZERO);
      hist2 = seed_hist(SEED_DEF);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic step(input logic v, input logic [1:0] ty, input logic [63:0] td, input logic mr);
      logic [65:0]  e;
      logic [121:0] r;
      logic         full;
      tvalid = v; ttype = ty; tdata = td; m_tready = mr;
      @(negedge clk);
      full = (exp_q.size() != 0);
      check("m_tvalid0", out0.tvalid, full);
      check("m_tvalid2", out2.tvalid, full);
      check("s_tready", in2.tready, !full || mr);
      if (full && mr) begin
         e = exp_q.pop_front();
         check("blk_plain", out0.tdata, e);
         r = descramble(out1.tdata[65:2], hist1);
         hist1 = r[121:64];
         check("blk_seed0", {r[63:0], out1.tdata[1:0]}, e);
         r = descramble(out2.tdata[65:2], hist2);
         hist2 = r[121:64];
         check("blk_scr", {r[63:0], out2.tdata[1:0]}, e);
         if (chk_zero) check("zero_payload", out1.tdata[65:2], 64'h0);
      end
      if (v && (!full || mr)) begin
         if (ty == 2'b01 || ty == 2'b10) begin
            exp_q.push_back({td, ty});
         end else begin
            exp_q.push_back({ERR_PAYLOAD, 2'b10});
            if (err_model != 16'hFFFF) err_model = err_model + 16'd1;
         end
      end
      @(posedge clk);
      #1;
      check("err_cnt0", err0, err_model);
      check("err_cnt2", err2, err_model);
   endtask

   initial begin
      logic [65:0] held;
      logic [1:0]  ty;

      hist1 = seed_hist(SEED_ZERO);
      hist2 = seed_hist(SEED_DEF);
      do_reset();

      // Plain data word, then drain
      step(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b1);
      check("plain_direct", out0.tdata, {64'h0123_4567_89AB_CDEF, 2'b01});
      step(1'b0, 2'b01, 64'h0, 1'b1);

      // Illegal type replaced by error block and counted
      step(1'b1, 2'b11, $urandom(), 1'b1);
      check("err_hdr", out0.tdata[1:0], 2'b10);
      check("err_bt", out0.tdata[9:2], 8'h1E);
      check("err_cnt_1", err0, 16'd1);
      for (int k = 0; k < 3; k++) step(1'b1, (k == 1) ? 2'b00 : 2'b11, {$urandom(), $urandom()}, 1'b1);
      step(1'b0, 2'b01, 64'h0, 1'b1);
      check("err_cnt_4", err2, 16'd4);

      // Zero seed and zero data keep the line all zeros
      do_reset();
      chk_zero = 1'b1;
      for (int k = 0; k < 100; k++) step(1'b1, 2'b01, 64'h0, 1'b1);
      step(1'b0, 2'b01, 64'h0, 1'b1);
      chk_zero = 1'b0;

      // Random traffic with random valid/ready against the default seed
      do_reset();
      for (int k = 0; k < 1000; k++) begin
         ty = ($urandom_range(0, 15) == 0) ? 2'(($urandom_range(0, 1) == 0) ? 0 : 3)
                                            : 2'($urandom_range(1, 2));
         step($urandom_range(0, 3) != 0, ty, {$urandom(), $urandom()}, $urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 64'h0, 1'b1);

      // Downstream stall: one word accepted, block held, scrambler frozen
      step(1'b1, 2'b01, {$urandom(), $urandom()}, 1'b0);
      held = out2.tdata;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 2'b01, {$urandom(), $urandom()}, 1'b0);
         check("stall_stable", out2.tdata, held);
      end
      for (int k = 0; k < 4; k++) step(1'b1, 2'b10, {$urandom(), $urandom()}, 1'b1);
      step(1'b0, 2'b01, 64'h0, 1'b1);

      // Reset in the middle of a burst
      for (int k = 0; k < 20; k++) step(1'b1, 2'(($urandom_range(0, 7) == 0) ? 3 : 1), {$urandom(), $urandom()}, 1'b1);
      do_reset();
      for (int k = 0; k < 20; k++) step(1'b1, 2'($urandom_range(1, 2)), {$urandom(), $urandom()}, 1'b1);
      step(1'b0, 2'b01, 64'h0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
